zero_indices_multi: RTL and testbench

Multi-lane, parametrised successor to the single-index zero enumerator. It accepts a W-bit vector over a valid/ready handshake and enumerates the positions of its target bits, up to N per beat, in ascending index order. Target bits are zeros or ones, selected per load. A backpressured response port and done, last and flush controls let it feed allocators and free-list walkers that consume several indices per cycle.

---
 rtl/zero_indices_multi.sv | 104 ++++++++++
 tb/tb_zero_indices_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_indices_multi.sv
// Enumerates target-bit positions (zeros or ones) of a loaded vector, up to N per beat, lowest first.
// Latency 1 from load to first beat; beats hold stable under resp_ready backpressure; flush abandons.
module zero_indices_multi #(
    parameter int W  = 32,
    parameter int N  = 2,
    parameter int IW = $clog2(W),
    parameter int CW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in_vector,
    input  logic            in_polarity,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [N-1:0]    resp_lane_valid,
    output logic [N*IW-1:0] resp_index,
    output logic            resp_last,
    output logic [CW-1:0]   resp_count,
    output logic            done_r,
    output logic            busy_r
);

    logic [W-1:0]  pend;
    logic [W-1:0]  load_mask;
    logic [W-1:0]  rem;
    logic [W-1:0]  emit;
    logic [CW-1:0] lane_cnt;
    logic          found;
    logic [IW-1:0] pos;
    logic          load;
    logic          xfer;

    assign in_ready  = ~busy_r;
    assign load      = in_valid & in_ready;
    assign load_mask = in_polarity ? in_vector : ~in_vector;
    assign resp_valid = busy_r & (pend != '0);

    // Peel the lowest remaining set bit once per lane; what is left over tells us
    // whether this beat drains the mask, i.e. popcount(pend) <= N.
    always_comb begin
        rem             = pend;
        emit            = '0;
        lane_cnt        = '0;
        found           = 1'b0;
        pos             = '0;
        resp_lane_valid = '0;
        resp_index      = '0;
        for (int i = 0; i < N; i++) begin
            found = 1'b0;
            pos   = '0;
            for (int b = 0; b < W; b++) begin
                if (!found && rem[b]) begin
                    found   = 1'b1;
                    pos     = IW'(b);
                    rem[b]  = 1'b0;
                    emit[b] = 1'b1;
                end
            end
            if (found && busy_r) begin
                resp_lane_valid[i]        = 1'b1;
                resp_index[i*IW +: IW]    = pos;
                lane_cnt                  = lane_cnt + CW'(1);
            end
        end
    end

    assign resp_last = resp_valid & (rem == '0);
    assign xfer      = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            resp_count <= '0;
        end else begin
            done_r <= 1'b0;
            if (flush && busy_r) begin
                // Any beat offered this cycle is dropped and not counted.
                pend   <= '0;
                busy_r <= 1'b0;
            end else if (load) begin
                pend       <= load_mask;
                resp_count <= '0;
                if (load_mask != '0) begin
                    busy_r <= 1'b1;
                end else begin
                    done_r <= 1'b1;
                end
            end else if (xfer) begin
                pend       <= pend & ~emit;
                resp_count <= resp_count + lane_cnt;
                if (resp_last) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zero_indices_multi.sv
// Scoreboard bench for zero_indices_multi at W=8, N=2.
module tb_zero_indices_multi;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    in_vector;
    logic            in_polarity;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [N-1:0]    resp_lane_valid;
    logic [N*IW-1:0] resp_index;
    logic            resp_last;
    logic [CW-1:0]   resp_count;
    logic            done_r;
    logic            busy_r;

    typedef struct packed {
        logic [N-1:0]    lv;
        logic [N*IW-1:0] idx;
        logic            last;
    } beat_t;

    beat_t sbq[$];
    int total = 0;
    int bad   = 0;

    zero_indices_multi #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .in_vector(in_vector), .in_polarity(in_polarity),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_lane_valid(resp_lane_valid), .resp_index(resp_index),
        .resp_last(resp_last), .resp_count(resp_count),
        .done_r(done_r), .busy_r(busy_r)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Build expected beats from the target list, N positions per beat.
    function automatic int push_expect(input logic [W-1:0] vec, input logic pol);
        logic [W-1:0] t;
        int pos_q[$];
        beat_t bt;
        t = pol ? vec : ~vec;
        for (int b = 0; b < W; b++) if (t[b]) pos_q.push_back(b);
        push_expect = pos_q.size();
        while (pos_q.size() > 0) begin
            bt = '0;
            for (int l = 0; l < N; l++) begin
                if (pos_q.size() > 0) begin
                    bt.lv[l] = 1'b1;
                    bt.idx[l*IW +: IW] = IW'(pos_q.pop_front());
                end
            end
            bt.last = (pos_q.size() == 0);
            sbq.push_back(bt);
        end
    endfunction

    task automatic do_load(input logic [W-1:0] vec, input logic pol, output int cnt);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_in_ready: got %b want 1", in_ready);
        end
        cnt = push_expect(vec, pol);
        in_vector   = vec;
        in_polarity = pol;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Drain the scoreboard; ready follows pat[0..plen-1] then stays high.
    task automatic run(input string name, input logic [15:0] pat, input int plen, input int exp_cnt);
        beat_t exp;
        bit    saw_last;
        bit    finished;
        finished = 0;
        for (int c = 0; c < 40 && !finished; c++) begin
            resp_ready = (c < plen) ? pat[c] : 1'b1;
            saw_last = 0;
            #0;
            total++;
            if (done_r !== 1'b0) begin
                bad++;
                $display("FAIL %s_done_early: got %b want 0", name, done_r);
            end
            if (resp_valid === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL %s_extra_beat: lanes %b idx %h", name, resp_lane_valid, resp_index);
                end else begin
                    exp = sbq[0];
                    if ({resp_lane_valid, resp_index, resp_last} !== {exp.lv, exp.idx, exp.last}) begin
                        bad++;
                        $display("FAIL %s_beat: got lv=%b idx=%h last=%b want lv=%b idx=%h last=%b",
                                 name, resp_lane_valid, resp_index, resp_last, exp.lv, exp.idx, exp.last);
                    end
                    if (resp_ready) begin
                        void'(sbq.pop_front());
                        saw_last = exp.last;
                    end
                end
            end
            step();
            if (saw_last) begin
                finished = 1;
                total++;
                if ({done_r, busy_r, in_ready, resp_count} !== {1'b1, 1'b0, 1'b1, CW'(exp_cnt)}) begin
                    bad++;
                    $display("FAIL %s_end: got done=%b busy=%b rdy=%b cnt=%0d want 1 0 1 %0d",
                             name, done_r, busy_r, in_ready, resp_count, exp_cnt);
                end
            end
        end
        resp_ready = 1'b0;
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: last beat not seen, %0d expected beats left", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_idle(input string name, input logic exp_done, input logic [CW-1:0] exp_cnt);
        total++;
        if ({resp_valid, resp_lane_valid, resp_last, in_ready, busy_r, done_r, resp_count}
            !== {1'b0, {N{1'b0}}, 1'b0, 1'b1, 1'b0, exp_done, exp_cnt}) begin
            bad++;
            $display("FAIL %s: got v=%b lv=%b last=%b rdy=%b busy=%b done=%b cnt=%0d want 0 0 0 1 0 %b %0d",
                     name, resp_valid, resp_lane_valid, resp_last, in_ready, busy_r, done_r,
                     resp_count, exp_done, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        in_vector = '0; in_polarity = 1'b0;
        step(); step();
        rst = 1'b0;
        check_idle("reset", 1'b0, '0);
    endtask

    task automatic test_basic();
        int n;
        do_load(8'b1010_0110, 1'b0, n);
        run("basic", 16'h0000, 0, n);
        step();
        check_idle("basic_done_pulse", 1'b0, CW'(4));
    endtask

    task automatic test_single();
        int n;
        do_load(8'b0001_0000, 1'b1, n);
        run("single", 16'h0000, 0, n);
    endtask

    task automatic test_no_targets();
        int n;
        step();
        do_load(8'hFF, 1'b0, n);
        check_idle("empty_load", 1'b1, '0);
        step();
        check_idle("empty_after", 1'b0, '0);
    endtask

    task automatic test_stall();
        int n;
        // ready sequence 0,0,1,0,1,1,1 (bit c = cycle c)
        do_load(8'h00, 1'b0, n);
        run("stall", 16'b111_0100, 7, n);
    endtask

    task automatic test_flush();
        int n;
        step();
        do_load(8'h00, 1'b0, n);
        resp_ready = 1'b1;
        total++;
        if ({resp_valid, resp_lane_valid, resp_index} !== {1'b1, 2'b11, 3'd1, 3'd0}) begin
            bad++;
            $display("FAIL flush_beat1: got v=%b lv=%b idx=%h want 1 11 08", resp_valid, resp_lane_valid, resp_index);
        end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; resp_ready = 1'b0;
        check_idle("flush_state", 1'b0, CW'(2));
        sbq.delete();
        step();
        check_idle("flush_no_done", 1'b0, CW'(2));
        do_load(8'hF0, 1'b0, n);
        total++;
        if (resp_count !== '0) begin
            bad++;
            $display("FAIL flush_count_restart: got %0d want 0", resp_count);
        end
        run("after_flush", 16'h0000, 0, n);
    endtask

    task automatic test_reset_mid();
        int n;
        step();
        do_load(8'b1010_0110, 1'b0, n);
        resp_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; resp_ready = 1'b0;
        sbq.delete();
        check_idle("rst_mid", 1'b0, '0);
        step();
        check_idle("rst_mid_no_done", 1'b0, '0);
        do_load(8'b1010_0110, 1'b0, n);
        run("rst_reload", 16'h0000, 0, n);
    endtask

    task automatic test_back_to_back();
        int n;
        // Each run ends with in_ready high, so the next load goes in immediately.
        do_load(8'b0101_0101, 1'b1, n);
        run("b2b_a", 16'h0000, 0, n);
        do_load(8'hFF, 1'b1, n);
        run("b2b_full", 16'h0000, 0, n);
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] v;
            logic         p;
            logic [15:0]  pat;
            v   = W'($urandom);
            p   = 1'($urandom);
            pat = 16'($urandom);
            do_load(v, p, n);
            if (n == 0) begin
                check_idle("rand_empty", 1'b1, '0);
            end else begin
                run("rand", pat, 16, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_no_targets();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
